// File: rtl/strm_arb_pkg.sv
// strm_arb_pkg: shared types and constants for the stream round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BURST)
//   STAT_W      : width of the optional per-requester beat counters
//   id_w()      : max(1, $clog2(n)); used for grantee IDs and the beat counter
package strm_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req    in  [N-1:0]   request vector
//   last   in  [IDW-1:0] most recent grantee; search starts at last+1
//   gnt_id out [IDW-1:0] first requester found (0 when none)
//   any    out 1         at least one request is present
module rr_pick
  import strm_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW-1:0] cand;

  // Walk N candidates starting after 'last'. The wrap tests N-1 explicitly
  // so that non-power-of-2 N never produces an out-of-range ID.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    cand   = last;
    for (int i = 0; i < N; i++) begin
      cand = (cand == IDW'(N - 1)) ? '0 : cand + IDW'(1);
      if (!any && req[cand]) begin
        gnt_id = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/strm_rr_arb.sv
// strm_rr_arb: round-robin arbiter sharing one stream FIFO write port among
// N requesters. A grant lasts until MAX_BURST beats are accepted or the
// grantee drops valid; each grant is preceded by one IDLE arbitration cycle.
// While a grant is held, valid/ready/data pass through combinationally.
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake [N-1:0]
//   req_data            per-requester data [N-1:0][WIDTH-1:0]
//   out_valid/out_ready FIFO write handshake (out_ready = FIFO ~full)
//   out_data            FIFO write data
//   grant_id            current grantee
//   busy                high while a grant is held
// Optional: define STRM_ARB_STATS_EN to add stat_clr (in) and
// stat_cnt (out, [N-1:0][15:0]) saturating accepted-beat counters.
module strm_rr_arb
  import strm_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int IDW      = id_w(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  output logic [N-1:0]               req_ready,
  input  logic [N-1:0][WIDTH-1:0]    req_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
`ifdef STRM_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [N-1:0][STAT_W-1:0]   stat_cnt
`endif
);

  localparam int BCW = id_w(MAX_BURST);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           sel_valid;
  logic           xfer;

  rr_pick #(.N(N)) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign sel_valid = req_valid[grant_q];
  assign out_data  = req_data[grant_q];
  assign grant_id  = grant_q;
  assign busy      = (state_q == BURST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    out_valid = 1'b0;
    req_ready = '0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_id;
          beat_d  = '0;
        end
      end
      BURST: begin
        out_valid          = sel_valid;
        req_ready[grant_q] = out_ready;
        xfer               = sel_valid && out_ready;
        if (!sel_valid) begin
          // Grantee withdrew: release the port, nothing moves this cycle.
          state_d = IDLE;
          last_d  = grant_q;
        end else if (xfer) begin
          if (beat_q == BCW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves last_grant at N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(N - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef STRM_ARB_STATS_EN
  logic [N-1:0][STAT_W-1:0] stat_q, stat_d;

  // Clear has priority over a coincident beat; counters stick at all-ones.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < N; i++) begin
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (xfer && (grant_q == IDW'(i)) && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_strm_rr_arb.sv
module tb_strm_rr_arb;
  import strm_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_data;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [1:0]          grant_id;
  logic                busy;

  logic [2:0]          rv3 = '0;
  logic [2:0]          rr3;
  logic [2:0][7:0]     rd3 = '0;
  logic                ov3;
  logic                ordy3 = 1'b1;
  logic [7:0]          od3;
  logic [1:0]          gid3;
  logic                busy3;

`ifdef STRM_ARB_STATS_EN
  logic                     stat_clr = 1'b0;
  logic [N-1:0][STAT_W-1:0] stat_cnt;
  logic                     stat_clr3 = 1'b0;
  logic [2:0][STAT_W-1:0]   stat_cnt3;
`endif

  always #5 clk = ~clk;

  strm_rr_arb #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef STRM_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  strm_rr_arb #(.N(3), .WIDTH(8), .MAX_BURST(1)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv3),
    .req_ready (rr3),
    .req_data  (rd3),
    .out_valid (ov3),
    .out_ready (ordy3),
    .out_data  (od3),
    .grant_id  (gid3),
    .busy      (busy3)
`ifdef STRM_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr3),
    .stat_cnt  (stat_cnt3)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int src_cnt[N];
  int src_seq[N];
  bit ready_en;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat payload: requester ID in the top nibble, marker bit, sequence number.
  function automatic logic [W-1:0] mk(input int id, input int seq);
    return W'((id << 12) | 32'h800 | (seq & 32'hff));
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (src_cnt[i] > 0);
      req_data[i]  = mk(i, src_seq[i]);
    end
    out_ready = ready_en;
  endtask

  // A handshake seen here completes at the next rising edge.
  task automatic monitor();
    logic [W-1:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexp_xfer", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("data", 32'(out_data), 32'(e));
        check("gid", 32'(grant_id), 32'(e[15:12]));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        src_cnt[i]--;
        src_seq[i]++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1 drive();
    #1 monitor();
  endtask

  task automatic run_q(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) cyc();
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0;
      src_seq[i] = 0;
    end
    ready_en = 1'b1;
    exp_q.delete();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c;
    int j;
    bit added;
    logic [W-1:0] held;

    // All four requesting with eight beats each: 0,1,2,3,0,1,2,3, bursts of 4
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 8;
      src_seq[i] = 0;
    end
    ready_en = 1'b1;
    drive();
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ov", 32'(out_valid), 32'(0));
    check("rst_rdy", 32'(req_ready), 32'(0));
    check("rst_gid", 32'(grant_id), 32'(0));
    check("rst_data", 32'(out_data), 32'(mk(0, 0)));
    for (int r = 0; r < 2; r++)
      for (int id = 0; id < N; id++)
        for (int b = 0; b < MB; b++)
          exp_q.push_back(mk(id, r * MB + b));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      check("t1_busy", 32'(busy), 32'((k % 5) != 4));
      if ((k % 5) != 4) check("t1_gid", 32'(grant_id), 32'((k / 5) % 4));
    end
    check("t1_drain", 32'(exp_q.size()), 32'(0));

    // Requester 2 drops valid after two beats; next arbitration starts at 3
    do_reset();
    src_cnt[2] = 2;
    exp_q.push_back(mk(2, 0));
    exp_q.push_back(mk(2, 1));
    exp_q.push_back(mk(3, 0));
    exp_q.push_back(mk(0, 0));
    added = 1'b0;
    for (c = 0; c < 20 && !added; c++) begin
      cyc();
      if (src_cnt[2] == 0) begin
        added = 1'b1;
        src_cnt[0] = 1;
        src_cnt[3] = 1;
      end
    end
    check("t2_two_beats", 32'(added), 32'(1));
    cyc();
    check("t2_drop_busy", 32'(busy), 32'(1));
    check("t2_drop_ov", 32'(out_valid), 32'(0));
    run_q(20);

    // Back-pressure for five cycles in the middle of a burst
    do_reset();
    src_cnt[1] = 6;
    for (int s = 0; s < 6; s++) exp_q.push_back(mk(1, s));
    for (c = 0; c < 20 && src_seq[1] < 2; c++) cyc();
    ready_en = 1'b0;
    held = mk(1, 2);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t3_hold_data", 32'(out_data), 32'(held));
      check("t3_hold_ov", 32'(out_valid), 32'(1));
      check("t3_hold_rdy", 32'(req_ready), 32'(0));
      check("t3_hold_busy", 32'(busy), 32'(1));
    end
    ready_en = 1'b1;
    for (c = 0; c < 20 && src_seq[1] < 4; c++) cyc();
    cyc();
    check("t3_end_busy", 32'(busy), 32'(0));
    run_q(20);

    // Reset during the second beat: beat dropped, requester 0 wins after
    do_reset();
    src_cnt[2] = 8;
    exp_q.push_back(mk(2, 0));
    for (c = 0; c < 20 && src_seq[2] < 1; c++) cyc();
    @(posedge clk);
    #1 drive();
    #1 check("t4_pre_ov", 32'(out_valid), 32'(1));
    rst = 1'b1;
    #1;
    check("t4_rst_ov", 32'(out_valid), 32'(0));
    check("t4_rst_rdy", 32'(req_ready), 32'(0));
    check("t4_rst_busy", 32'(busy), 32'(0));
    check("t4_q", 32'(exp_q.size()), 32'(0));
    src_cnt[0] = 2;
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 1));
    for (int s = 1; s < 8; s++) exp_q.push_back(mk(2, s));
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    run_q(60);

    // N=3 instance, all requesting: grants 0,1,2,0 and never ID 3
    do_reset();
    rv3 = 3'b111;
    j = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      if (busy3) begin
        check("n3_gid", 32'(gid3), 32'(j % 3));
        check("n3_range", 32'(gid3 < 2'd3), 32'(1));
        j++;
      end
    end
    check("n3_grants", 32'(j), 32'(4));
    rv3 = '0;

`ifdef STRM_ARB_STATS_EN
    // Seven beats counted, then a clear coinciding with a beat wins
    do_reset();
    src_cnt[1] = 7;
    for (int s = 0; s < 7; s++) exp_q.push_back(mk(1, s));
    run_q(40);
    cyc();
    check("st_cnt1", 32'(stat_cnt[1]), 32'(7));
    check("st_cnt0", 32'(stat_cnt[0]), 32'(0));
    src_cnt[1] = 1;
    exp_q.push_back(mk(1, 7));
    stat_clr = 1'b1;
    run_q(20);
    cyc();
    stat_clr = 1'b0;
    check("st_clr_wins", 32'(stat_cnt[1]), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
